// File: rtl/serial_rx.sv
// serial_rx: oversampled UART-style receiver, 8N1 framing.
// The line is synchronised, the start bit is confirmed at mid-bit and every
// following bit is sampled one bit period later; a good stop bit publishes
// the byte, a low stop bit raises a one-cycle frame error instead.
module serial_rx #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       sysclk,
  input  logic       reset_n,
  input  logic       receive_i,
  input  logic       sample_tick_i,
  output logic [7:0] data_o,
  output logic       data_valid_o,
  output logic       frame_error_o,
  output logic       busy_o
);

  localparam int unsigned TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [1:0]      rx_sync;
  logic            rx_prev;
  logic            rx;
  logic            fall;
  logic            tick_half;
  logic            tick_full;
  logic [TW-1:0]   tick_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift_reg;

  assign rx        = rx_sync[1];
  assign fall      = rx_prev & ~rx;
  assign tick_half = sample_tick_i && (tick_cnt == HALF_M1);
  assign tick_full = sample_tick_i && (tick_cnt == FULL_M1);

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      rx_sync <= '1;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], receive_i};
      rx_prev <= rx_sync[1];
    end
  end

  // State register.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; the counters only move on sample ticks.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (fall) state_nxt = START;
      START: if (tick_half) state_nxt = rx ? IDLE : DATA;
      DATA:  if (tick_full && (bit_cnt == 3'd7)) state_nxt = STOP;
      STOP:  if (tick_full) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: busy follows the registered state.
  always_comb begin
    busy_o = (state != IDLE);
  end

  // Counters, shift register and the registered result pulses.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt      <= '0;
      bit_cnt       <= '0;
      shift_reg     <= '0;
      data_o        <= '0;
      data_valid_o  <= 1'b0;
      frame_error_o <= 1'b0;
    end else begin
      data_valid_o  <= 1'b0;
      frame_error_o <= 1'b0;
      case (state)
        IDLE: begin
          tick_cnt <= '0;
          bit_cnt  <= '0;
        end
        START: begin
          if (sample_tick_i) begin
            if (tick_cnt == HALF_M1) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        DATA: begin
          if (sample_tick_i) begin
            if (tick_cnt == FULL_M1) begin
              shift_reg <= {rx, shift_reg[7:1]};
              tick_cnt  <= '0;
              bit_cnt   <= bit_cnt + 3'd1;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        STOP: begin
          if (sample_tick_i) begin
            if (tick_cnt == FULL_M1) begin
              tick_cnt <= '0;
              if (rx) begin
                data_o       <= shift_reg;
                data_valid_o <= 1'b1;
              end else begin
                frame_error_o <= 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        default: begin
          tick_cnt <= '0;
          bit_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_rx.sv
// tb_serial_rx: scoreboard bench for serial_rx. The driver serialises
// frames in units of sample ticks and queues the expected outcome of each;
// an independent monitor pops the queue whenever a pulse appears.
module tb_serial_rx;

  localparam int unsigned OS = 16;

  logic       sysclk;
  logic       reset_n;
  logic       receive_i;
  logic       sample_tick_i;
  logic [7:0] data_o;
  logic       data_valid_o;
  logic       frame_error_o;
  logic       busy_o;

  serial_rx #(.OVERSAMPLE(OS)) dut (
    .sysclk        (sysclk),
    .reset_n       (reset_n),
    .receive_i     (receive_i),
    .sample_tick_i (sample_tick_i),
    .data_o        (data_o),
    .data_valid_o  (data_valid_o),
    .frame_error_o (frame_error_o),
    .busy_o        (busy_o)
  );

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [7:0]  last_good = 8'h00;
  int unsigned tick_period = 4;
  bit          tick_en = 1'b1;
  int unsigned tick_cnt = 0;

  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  // Tick generator: one-cycle pulse every tick_period cycles while enabled.
  initial begin
    sample_tick_i = 1'b0;
    forever begin
      @(negedge sysclk);
      if (tick_cnt + 1 >= tick_period) tick_cnt = 0;
      else tick_cnt++;
      sample_tick_i = tick_en && (tick_cnt == 0);
    end
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge sysclk);
      #1;
      if (data_valid_o && frame_error_o) begin
        checks++;
        errors++;
        $display("FAIL both_pulses: valid=%b error=%b required not both", data_valid_o, frame_error_o);
      end
      if (data_valid_o || frame_error_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: valid=%b error=%b data_o=%h, none required",
                   data_valid_o, frame_error_o, data_o);
        end else begin
          e = exp_q.pop_front();
          chk1("pulse_is_error", frame_error_o, e.is_err);
          if (!e.is_err) last_good = e.data;
          chk8("data_o_at_pulse", data_o, last_good);
        end
      end
    end
  end

  // Returns just after the posedge that carries the n-th sample tick.
  task automatic wait_ticks(input int n);
    int guard;
    for (int k = 0; k < n; k++) begin
      guard = 0;
      do begin
        @(posedge sysclk);
        guard++;
      end while (!sample_tick_i && guard < 1000);
      if (guard >= 1000) begin
        checks++;
        errors++;
        $display("FAIL tick_timeout: no tick within %0d cycles, required one", guard);
        return;
      end
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge sysclk);
    receive_i = b;
    wait_ticks(OS);
  endtask

  task automatic idle_bits(input int n);
    for (int k = 0; k < n; k++) send_bit(1'b1);
  endtask

  task automatic do_reset();
    @(negedge sysclk);
    reset_n = 1'b0;
    exp_q.delete();
    last_good = 8'h00;
    repeat (3) @(negedge sysclk);
    chk8("reset_data_o", data_o, 8'h00);
    chk1("reset_valid", data_valid_o, 1'b0);
    chk1("reset_error", frame_error_o, 1'b0);
    chk1("reset_busy", busy_o, 1'b0);
    receive_i = 1'b1;
    reset_n   = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int nstop, input bit pause);
    exp_t e;
    send_bit(1'b0);
    #1;
    chk1("busy_in_frame", busy_o, 1'b1);
    for (int i = 0; i < 8; i++) begin
      if (pause && i == 3) begin
        @(negedge sysclk);
        receive_i = d[i];
        wait_ticks(OS / 2);
        tick_en = 1'b0;
        repeat (100) @(negedge sysclk);
        tick_en = 1'b1;
        wait_ticks(OS / 2);
      end else begin
        send_bit(d[i]);
      end
    end
    e.is_err = !stop_ok;
    e.data   = d;
    exp_q.push_back(e);
    send_bit(stop_ok);
    for (int k = 1; k < nstop; k++) send_bit(1'b1);
  endtask

  task automatic glitch();
    @(negedge sysclk);
    receive_i = 1'b0;
    wait_ticks(3);
    @(negedge sysclk);
    receive_i = 1'b1;
    wait_ticks(OS);
    #1;
    chk1("busy_after_glitch", busy_o, 1'b0);
  endtask

  initial begin
    bit err;
    int guard;
    reset_n   = 1'b0;
    receive_i = 1'b1;
    do_reset();
    idle_bits(2);

    // Basic frame 0xA5 with ticks every 4 cycles.
    send_frame(8'hA5, 1'b1, 1, 1'b0);
    idle_bits(1);
    #1;
    chk8("data_after_A5", data_o, 8'hA5);
    chk1("idle_after_A5", busy_o, 1'b0);

    // Short low pulse is rejected as a glitch.
    glitch();
    chk8("data_after_glitch", data_o, 8'hA5);

    // Bad stop bit, then a long break: exactly one error.
    send_frame(8'h3C, 1'b0, 1, 1'b0);
    wait_ticks(40 * OS);
    #1;
    chk8("data_after_break", data_o, 8'hA5);
    chk1("idle_in_break", busy_o, 1'b0);
    @(negedge sysclk);
    receive_i = 1'b1;
    idle_bits(2);

    // Back-to-back frames, one then two stop bits.
    send_frame(8'h00, 1'b1, 1, 1'b0);
    send_frame(8'hFF, 1'b1, 1, 1'b0);
    send_frame(8'h00, 1'b1, 2, 1'b0);
    send_frame(8'hFF, 1'b1, 2, 1'b0);
    idle_bits(1);
    #1;
    chk8("data_after_pairs", data_o, 8'hFF);

    // Reset in the middle of data bit 4 of 0x81, then a full 0x81.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'(8'h81 >> i));
    @(negedge sysclk);
    receive_i = 1'b0;
    wait_ticks(OS / 2);
    do_reset();
    idle_bits(2);
    #1;
    chk1("idle_after_abort", busy_o, 1'b0);
    chk8("data_after_abort", data_o, 8'h00);
    send_frame(8'h81, 1'b1, 1, 1'b0);
    idle_bits(1);
    #1;
    chk8("data_after_81", data_o, 8'h81);

    // Ticks paused for 100 cycles mid-frame.
    send_frame(8'h5A, 1'b1, 1, 1'b1);
    idle_bits(1);
    #1;
    chk8("data_after_pause", data_o, 8'h5A);

    // Randomised traffic: tick rate, data, stop count, errors and glitches.
    for (int n = 0; n < 40; n++) begin
      @(negedge sysclk);
      tick_period = $urandom_range(1, 5);
      idle_bits($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) glitch();
      err = ($urandom_range(0, 7) == 0);
      send_frame(8'($urandom), !err, $urandom_range(1, 2), 1'b0);
      if (err) begin
        wait_ticks(OS * $urandom_range(1, 3));
        @(negedge sysclk);
        receive_i = 1'b1;
        idle_bits(1);
      end
    end

    guard = 0;
    while (exp_q.size() > 0 && guard < 2000) begin
      @(negedge sysclk);
      guard++;
    end
    chk_int("pending_expectations", exp_q.size(), 0);
    repeat (200) @(negedge sysclk);
    chk8("final_data_o", data_o, last_good);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_rx.md
SERIAL_RX -- requirements
Module: serial_rx

Interface
REQ-001 Parameter OVERSAMPLE, default 16: number of sample_tick_i pulses per bit period, even, >= 4.
REQ-002 sysclk  in  1  system clock; all state updates on its rising edge.
REQ-003 reset_n  in  1  reset; one clock, reset asynchronous and active-low.
REQ-004 receive_i  in  1  asynchronous serial line, idle high.
REQ-005 sample_tick_i  in  1  one-sysclk pulse at OVERSAMPLE x baud rate.
REQ-006 data_o  out  8  last correctly framed byte.
REQ-007 data_valid_o  out  1  one-cycle pulse when data_o is updated.
REQ-008 frame_error_o  out  1  one-cycle pulse when a stop bit is sampled low.
REQ-009 busy_o  out  1  high in every state except IDLE.

Function
REQ-010 The block SHALL pass receive_i through a 2-flop synchronizer (flops reset to 1) and use only the synchronized value.
REQ-011 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, >= 1 stop bit (1); only the first stop bit is checked.
REQ-012 The FSM SHALL have states IDLE, START, DATA, STOP, with a tick counter (width ceil(log2(OVERSAMPLE))) and a 3-bit bit counter.
REQ-013 IDLE: on a synchronized falling edge (previous 1, current 0) -> START; tick counter cleared to 0; a line that is already low does not start a frame.
REQ-014 START: tick counter increments on each sample_tick_i; on the tick where it equals OVERSAMPLE/2-1, sample the line: 0 -> DATA with both counters cleared; 1 -> IDLE (glitch rejected, no output pulse).
REQ-015 DATA: on the tick where the tick counter equals OVERSAMPLE-1, sample the line into the shift register MSB (shift right) and clear the tick counter; the bit counter then increments, and after bit 7 the FSM -> STOP.
REQ-016 STOP: on the tick where the tick counter equals OVERSAMPLE-1, sample the line: 1 -> data_o <= shift register, data_valid_o = 1 for the next cycle; 0 -> frame_error_o = 1 for the next cycle, data_o unchanged; both cases -> IDLE.
REQ-017 Counters SHALL advance only on cycles with sample_tick_i = 1; without ticks the FSM holds its state.
REQ-018 data_valid_o and frame_error_o SHALL never be high in the same cycle and SHALL each be high for exactly one sysclk per frame at most.
REQ-019 After a frame error, IDLE SHALL require the line to return high before a new falling edge can start a frame (break condition yields a single error).
REQ-020 A new frame whose start edge arrives in the cycle the FSM enters IDLE SHALL be accepted (back-to-back frames with 1 stop bit).
REQ-021 busy_o SHALL assert the cycle after IDLE -> START and deassert the cycle the FSM re-enters IDLE.

Reset
REQ-022 When reset_n is asserted, the block SHALL immediately set state IDLE, both counters 0, shift register 0x00, data_o 0x00, data_valid_o 0, frame_error_o 0, busy_o 0, and synchronizer flops 1.
REQ-023 Reset asserted mid-frame SHALL discard the partial byte without emitting a pulse; reception resumes at the next falling edge after release.

Verification
REQ-024 Frame 0xA5 (line 0,1,0,1,0,0,1,0,1,1), tick every 4 sysclk, OVERSAMPLE=16 -> data_o = 0xA5, data_valid_o high for exactly 1 cycle, frame_error_o stays 0.
REQ-025 Line low for 3 ticks and then high -> FSM returns to IDLE, no pulses, data_o unchanged, busy_o low again.
REQ-026 Frame 0x3C with stop bit 0 -> frame_error_o pulses once, data_o keeps the previous 0xA5; line held low for 40 bit times -> no further pulses until the line goes high.
REQ-027 Back-to-back frames 0x00 then 0xFF, each with 1 stop bit, then with 2 stop bits -> 2 data_valid_o pulses per pair, with data_o = 0x00 and then 0xFF.
REQ-028 reset_n pulsed low during data bit 4 of 0x81, then a full frame 0x81 -> no pulse for the aborted frame, then data_o = 0x81 with 1 valid pulse.
REQ-029 sample_tick_i held low for 100 cycles mid-frame, then resumed -> frame is still received correctly (0x5A in, 0x5A out).
